// File: rtl/axi4_lite_master_sequencer.sv
// AXI4-Lite initiator: one command in, one single-beat AXI transaction out, one response back.
// Optional per-phase watchdog abort is built when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master_sequencer #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ERR_CNT_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_WIDTH-1:0]    cmd_addr,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic                     cmd_write,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic [1:0]               rsp_resp,
  output logic                     rsp_write,
  output logic                     rsp_timeout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ADDR_WIDTH-1:0]    awaddr,
  output logic [2:0]               awprot,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [DATA_WIDTH-1:0]    wdata,
  output logic [DATA_WIDTH/8-1:0]  wstrb,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic [ADDR_WIDTH-1:0]    araddr,
  output logic [2:0]               arprot,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [DATA_WIDTH-1:0]    rdata,
  input  logic [1:0]               rresp,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic                     busy
);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} StateT;

  StateT                    r_state;
  logic                     r_write;
  logic                     r_awDone;
  logic                     r_wDone;
  logic [ADDR_WIDTH-1:0]    r_awaddr;
  logic [2:0]               r_awprot;
  logic                     r_awvalid;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [DATA_WIDTH/8-1:0]  r_wstrb;
  logic                     r_wvalid;
  logic                     r_bready;
  logic [ADDR_WIDTH-1:0]    r_araddr;
  logic [2:0]               r_arprot;
  logic                     r_arvalid;
  logic                     r_rready;
  logic [DATA_WIDTH-1:0]    r_rspData;
  logic [1:0]               r_rspResp;
  logic                     r_rspWrite;
  logic                     r_rspValid;
  logic [ERR_CNT_WIDTH-1:0] r_errCount;

  logic w_awHs;
  logic w_wHs;
  logic w_arHs;

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 1) begin : g_badParams
    $error("axi4_lite_master_sequencer: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 1");
  end

  assign w_awHs = r_awvalid & awready;
  assign w_wHs  = r_wvalid & wready;
  assign w_arHs = r_arvalid & arready;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  StateT           r_prevState;
  logic [TO_W-1:0] r_phaseCnt;
  logic [TO_W-1:0] w_phaseCnt;
  logic            w_timeout;
  logic            r_rspTimeout;

  // The phase count restarts whenever the state differs from the one seen last cycle.
  assign w_phaseCnt = (r_state != r_prevState) ? '0 : r_phaseCnt;
  assign w_timeout  = (r_state inside {WR, WR_RESP, RD_ADDR, RD_DATA}) &&
                      (w_phaseCnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prevState  <= IDLE;
      r_phaseCnt   <= '0;
      r_rspTimeout <= 1'b0;
    end else begin
      r_prevState <= r_state;
      r_phaseCnt  <= w_phaseCnt + 1'b1;
      if (w_timeout) begin
        r_rspTimeout <= 1'b1;
      end else if (r_state == IDLE) begin
        r_rspTimeout <= 1'b0;
      end
    end
  end

  assign rsp_timeout = r_rspTimeout;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_write    <= 1'b0;
      r_awDone   <= 1'b0;
      r_wDone    <= 1'b0;
      r_awaddr   <= '0;
      r_awprot   <= 3'b000;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_araddr   <= '0;
      r_arprot   <= 3'b000;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_rspData  <= '0;
      r_rspResp  <= 2'b00;
      r_rspWrite <= 1'b0;
      r_rspValid <= 1'b0;
      r_errCount <= '0;
    end else begin
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
      // Watchdog abort deliberately drops valids mid-handshake to free a hung bus.
      if (w_timeout) begin
        r_awvalid  <= 1'b0;
        r_wvalid   <= 1'b0;
        r_bready   <= 1'b0;
        r_arvalid  <= 1'b0;
        r_rready   <= 1'b0;
        r_rspData  <= '0;
        r_rspResp  <= 2'b10;
        r_rspWrite <= r_write;
        r_rspValid <= 1'b1;
        if (r_errCount != '1) r_errCount <= r_errCount + 1'b1;
        r_state    <= RSP;
      end else
`endif
      begin
        case (r_state)
          IDLE: begin
            if (cmd_valid) begin
              r_write <= cmd_write;
              if (cmd_write) begin
                r_awaddr  <= cmd_addr;
                r_awprot  <= 3'b000;
                r_wdata   <= cmd_data;
                r_wstrb   <= '1;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awDone  <= 1'b0;
                r_wDone   <= 1'b0;
                r_state   <= WR;
              end else begin
                r_araddr  <= cmd_addr;
                r_arprot  <= 3'b000;
                r_arvalid <= 1'b1;
                r_state   <= RD_ADDR;
              end
            end
          end
          WR: begin
            if (w_awHs) begin
              r_awvalid <= 1'b0;
              r_awDone  <= 1'b1;
            end
            if (w_wHs) begin
              r_wvalid <= 1'b0;
              r_wDone  <= 1'b1;
            end
            if ((r_awDone || w_awHs) && (r_wDone || w_wHs)) begin
              r_bready <= 1'b1;
              r_state  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (bvalid && r_bready) begin
              r_bready   <= 1'b0;
              r_rspData  <= '0;
              r_rspResp  <= bresp;
              r_rspWrite <= 1'b1;
              r_rspValid <= 1'b1;
              if (bresp != 2'b00 && r_errCount != '1) r_errCount <= r_errCount + 1'b1;
              r_state    <= RSP;
            end
          end
          RD_ADDR: begin
            if (w_arHs) begin
              r_arvalid <= 1'b0;
              r_rready  <= 1'b1;
              r_state   <= RD_DATA;
            end
          end
          RD_DATA: begin
            if (rvalid && r_rready) begin
              r_rready   <= 1'b0;
              r_rspData  <= rdata;
              r_rspResp  <= rresp;
              r_rspWrite <= 1'b0;
              r_rspValid <= 1'b1;
              if (rresp != 2'b00 && r_errCount != '1) r_errCount <= r_errCount + 1'b1;
              r_state    <= RSP;
            end
          end
          RSP: begin
            if (rsp_ready) begin
              r_rspValid <= 1'b0;
              r_state    <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign awaddr    = r_awaddr;
  assign awprot    = r_awprot;
  assign awvalid   = r_awvalid;
  assign wdata     = r_wdata;
  assign wstrb     = r_wstrb;
  assign wvalid    = r_wvalid;
  assign bready    = r_bready;
  assign araddr    = r_araddr;
  assign arprot    = r_arprot;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign rsp_data  = r_rspData;
  assign rsp_resp  = r_rspResp;
  assign rsp_write = r_rspWrite;
  assign rsp_valid = r_rspValid;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_axi4_lite_master_sequencer.sv
// Scoreboard bench for axi4_lite_master_sequencer with a cycle-driven AXI4-Lite slave model.
// A second instance with a 2-bit error counter shares the stimulus to exercise saturation.
`timescale 1ns/1ps
module tb_axi4_lite_master_sequencer;

  localparam int AW     = 32;
  localparam int ECW    = 16;
  localparam int TO     = 16;
  localparam int MAXCYC = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_data;
  logic          cmd_write;
  logic          cmd_valid;
  logic          rsp_ready;
  logic          awready;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid;

  logic           cmd_ready, rsp_write, rsp_timeout, rsp_valid;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_resp;
  logic [AW-1:0]  awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic           awvalid, wvalid, bready, arvalid, rready, busy;
  logic [31:0]    wdata;
  logic [3:0]     wstrb;
  logic [ECW-1:0] err_count;

  logic          d2_cmd_ready, d2_rsp_write, d2_rsp_timeout, d2_rsp_valid;
  logic [31:0]   d2_rsp_data;
  logic [1:0]    d2_rsp_resp;
  logic [AW-1:0] d2_awaddr, d2_araddr;
  logic [2:0]    d2_awprot, d2_arprot;
  logic          d2_awvalid, d2_wvalid, d2_bready, d2_arvalid, d2_rready, d2_busy;
  logic [31:0]   d2_wdata;
  logic [3:0]    d2_wstrb;
  logic [1:0]    d2_err_count;

  always #5 clk = ~clk;

  axi4_lite_master_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ERR_CNT_WIDTH(ECW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_write(cmd_write), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_resp(rsp_resp), .rsp_write(rsp_write), .rsp_timeout(rsp_timeout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .err_count(err_count), .busy(busy)
  );

  axi4_lite_master_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(32), .ERR_CNT_WIDTH(2), .TIMEOUT_CYCLES(TO)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_write(cmd_write), .cmd_valid(cmd_valid),
    .cmd_ready(d2_cmd_ready),
    .rsp_data(d2_rsp_data), .rsp_resp(d2_rsp_resp), .rsp_write(d2_rsp_write),
    .rsp_timeout(d2_rsp_timeout), .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready),
    .awaddr(d2_awaddr), .awprot(d2_awprot), .awvalid(d2_awvalid), .awready(awready),
    .wdata(d2_wdata), .wstrb(d2_wstrb), .wvalid(d2_wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(d2_bready),
    .araddr(d2_araddr), .arprot(d2_arprot), .arvalid(d2_arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(d2_rready),
    .err_count(d2_err_count), .busy(d2_busy)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        write;
    logic        timeout;
    int          err;
    int          err2;
  } RspT;

  RspT expQ[$];
  int  checks = 0;
  int  failures = 0;
  int  expErr = 0;
  int  expErr2 = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Issues one command and plays the slave side cycle by cycle; called and returns on a negedge.
  task automatic applyStimulus(input string name, input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input int addrDelay, input int wDelay,
                               input logic [1:0] resp, input logic [31:0] rdVal, input int rspHold,
                               input int expAddrCycles, input int expLatency, input logic expTimeout);
    RspT e;
    RspT cur;
    int  cyc = 0, awHigh = 0, wHigh = 0, arHigh = 0, rspCnt = 0;
    bit  awDone = 0, wDone = 0, arDone = 0, bDone = 0, rDone = 0;
    bit  awPend = 0, wPend = 0, arPend = 0, bPend = 0, rPend = 0, rspPend = 0, rspDone = 0;

    checkOutput({name, ".cmdReady"}, cmd_ready, 1'b1);
    e.data    = (isWrite || expTimeout) ? 32'h0 : rdVal;
    e.resp    = expTimeout ? 2'b10 : resp;
    e.write   = isWrite;
    e.timeout = expTimeout;
    if (e.resp != 2'b00) begin
      if (expErr < (1 << ECW) - 1) expErr++;
      if (expErr2 < 3) expErr2++;
    end
    e.err  = expErr;
    e.err2 = expErr2;
    expQ.push_back(e);
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_write = isWrite;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;

    while (!rspDone && cyc < MAXCYC) begin
      cyc++;
      if (rspPend) begin
        rsp_ready = 1'b0;
        rspDone   = 1;
        checkOutput({name, ".rspDrop"}, rsp_valid, 1'b0);
      end else begin
        if (awPend) begin awready = 1'b0; awDone = 1; awPend = 0; end
        if (wPend)  begin wready  = 1'b0; wDone  = 1; wPend  = 0; end
        if (arPend) begin arready = 1'b0; arDone = 1; arPend = 0; end
        if (bPend)  begin bvalid  = 1'b0; bDone  = 1; bPend  = 0; end
        if (rPend)  begin rvalid  = 1'b0; rDone  = 1; rPend  = 0; end

        if (awvalid) begin
          awHigh++;
          checkOutput({name, ".awaddr"}, awaddr, addr);
          checkOutput({name, ".awprot"}, awprot, 3'b000);
          if (!awDone && awHigh > addrDelay) begin awready = 1'b1; awPend = 1; end
        end
        if (wvalid) begin
          wHigh++;
          checkOutput({name, ".wdata"}, wdata, data);
          checkOutput({name, ".wstrb"}, wstrb, 4'hF);
          if (!wDone && wHigh > wDelay) begin wready = 1'b1; wPend = 1; end
        end
        if (arvalid) begin
          arHigh++;
          checkOutput({name, ".araddr"}, araddr, addr);
          if (!arDone && arHigh > addrDelay) begin arready = 1'b1; arPend = 1; end
        end
        if (isWrite && awDone && wDone && !bDone && !bvalid) begin bvalid = 1'b1; bresp = resp; end
        if (bvalid && bready) bPend = 1;
        if (!isWrite && arDone && !rDone && !rvalid) begin
          rvalid = 1'b1; rdata = rdVal; rresp = resp;
        end
        if (rvalid && rready) rPend = 1;

        if (rsp_valid) begin
          rspCnt++;
          if (rspCnt == 1) begin
            checkOutput({name, ".queueDepth"}, expQ.size(), 1);
            if (expQ.size() > 0) cur = expQ.pop_front();
            checkOutput({name, ".errCount"}, err_count, cur.err);
            checkOutput({name, ".errCount2b"}, d2_err_count, cur.err2);
            if (expLatency > 0) checkOutput({name, ".latency"}, cyc, expLatency);
          end
          checkOutput({name, ".rspData"}, rsp_data, cur.data);
          checkOutput({name, ".rspResp"}, rsp_resp, cur.resp);
          checkOutput({name, ".rspWrite"}, rsp_write, cur.write);
          checkOutput({name, ".rspTimeout"}, rsp_timeout, cur.timeout);
          if (rspCnt > rspHold) begin rsp_ready = 1'b1; rspPend = 1; end
        end
      end
      if (!rspDone) @(negedge clk);
    end

    if (!rspDone) checkOutput({name, ".rspWithinBound"}, cyc, MAXCYC + 1);
    awready = 1'b0; wready = 1'b0; arready = 1'b0; bvalid = 1'b0; rvalid = 1'b0; rsp_ready = 1'b0;
    if (isWrite) begin
      checkOutput({name, ".awCycles"}, awHigh, expAddrCycles);
      checkOutput({name, ".wCycles"}, wHigh, wDelay + 1);
      checkOutput({name, ".arCycles"}, arHigh, 0);
    end else begin
      checkOutput({name, ".arCycles"}, arHigh, expAddrCycles);
      checkOutput({name, ".awCycles"}, awHigh, 0);
    end
    checkOutput({name, ".rspHoldCycles"}, rspCnt, rspHold + 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput({name, ".singleRsp"}, rsp_valid, 1'b0);
      checkOutput({name, ".idleBusy"}, busy, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_addr = '0; cmd_data = '0; cmd_write = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.awvalid", awvalid, 1'b0);
    checkOutput("reset.wvalid", wvalid, 1'b0);
    checkOutput("reset.arvalid", arvalid, 1'b0);
    checkOutput("reset.bready", bready, 1'b0);
    checkOutput("reset.rready", rready, 1'b0);
    checkOutput("reset.rspValid", rsp_valid, 1'b0);
    checkOutput("reset.rspData", rsp_data, 32'h0);
    checkOutput("reset.errCount", err_count, 16'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.cmdReady", cmd_ready, 1'b1);
    checkOutput("reset.busy", busy, 1'b0);

    applyStimulus("wrBasic", 1'b1, 32'h0000_0040, 32'h0000_1234, 0, 0, 2'b00, 32'h0, 0, 1, 3, 1'b0);
    applyStimulus("rdBasic", 1'b0, 32'h0000_0080, 32'h0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 1, 3, 1'b0);
    applyStimulus("rdSlowAr", 1'b0, 32'h0000_0124, 32'h0, 4, 0, 2'b00, 32'h0000_ABCD, 0, 5, -1, 1'b0);
    applyStimulus("wrSlowAw", 1'b1, 32'h0000_0200, 32'h0000_55AA, 3, 0, 2'b00, 32'h0, 0, 4, -1, 1'b0);
    applyStimulus("wrSlowW", 1'b1, 32'h0000_0204, 32'h0000_CAFE, 0, 2, 2'b00, 32'h0, 1, 1, -1, 1'b0);
    applyStimulus("wrErrHold", 1'b1, 32'h0000_0300, 32'h0000_0001, 0, 0, 2'b10, 32'h0, 5, 1, 3, 1'b0);
    applyStimulus("wrErr2", 1'b1, 32'h0000_0304, 32'h0000_0002, 0, 0, 2'b10, 32'h0, 0, 1, 3, 1'b0);
    checkOutput("afterTwoErr.errCount", err_count, 16'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rdErr", 1'b0, 32'h0000_0400 + 32'(4 * i), 32'h0, i, 0, (i == 1) ? 2'b11 : 2'b10,
                    32'h0000_1000 + 32'(i), 0, i + 1, -1, 1'b0);
    end
    checkOutput("afterFiveErr.errCount", err_count, 16'd5);
    checkOutput("afterFiveErr.errCount2bSat", d2_err_count, 2'd3);

    // Abort a read while it sits in the data phase with rready high.
    cmd_addr = 32'h0000_0500; cmd_write = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    arready   = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    checkOutput("midRst.rreadyBefore", rready, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("midRst.rready", rready, 1'b0);
    checkOutput("midRst.arvalid", arvalid, 1'b0);
    checkOutput("midRst.rspValid", rsp_valid, 1'b0);
    checkOutput("midRst.busy", busy, 1'b0);
    checkOutput("midRst.errCount", err_count, 16'h0);
    checkOutput("midRst.errCount2b", d2_err_count, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    expErr  = 0;
    expErr2 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postRst.noRsp", rsp_valid, 1'b0);
      checkOutput("postRst.cmdReady", cmd_ready, 1'b1);
    end
    applyStimulus("wrAfterRst", 1'b1, 32'h0000_0600, 32'h0BAD_F00D, 0, 0, 2'b00, 32'h0, 0, 1, 3, 1'b0);

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    applyStimulus("rdTimeout", 1'b0, 32'h0000_0700, 32'h0, 100000, 0, 2'b00, 32'h0, 0, TO, -1, 1'b1);
    checkOutput("rdTimeout.errCount", err_count, 16'd1);
`endif

    checkOutput("end.queueEmpty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
